// File: rtl/fizzbuzz_seq.sv
// FizzBuzz line sequencer: counts 1..LIMIT and streams one ASCII line per value
// ("Fizz", "Buzz", "FizzBuzz" or the decimal number, each followed by CR LF) over
// a valid/ready byte handshake to a UART transmitter.
// Optional build macro FIZZBUZZ_LOOP_EN: restart from 1 after LIMIT instead of stopping.
module fizzbuzz_seq #(
  parameter int unsigned LIMIT        = 100,
  parameter int unsigned PAUSE_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic [7:0] led
);

  typedef enum logic [1:0] {StIdle, StEmit, StGap, StDone} state_e;

  localparam logic [9:0] LimitVal = 10'(LIMIT);
  localparam int unsigned GapW = (PAUSE_CYCLES < 2) ? 1 : $clog2(PAUSE_CYCLES + 1);
  localparam logic [GapW-1:0] GapLoad = GapW'(PAUSE_CYCLES);

  localparam logic [7:0] ChCr = 8'h0D;
  localparam logic [7:0] ChLf = 8'h0A;

  state_e          state_q, state_d;
  logic [9:0]      value_q, value_d;
  logic [1:0]      mod3_q, mod3_d;
  logic [2:0]      mod5_q, mod5_d;
  logic [3:0]      bcd_h_q, bcd_h_d, bcd_t_q, bcd_t_d, bcd_o_q, bcd_o_d;
  logic [3:0]      idx_q, idx_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [7:0]      led_q, led_d;

  // Incremented counter values, used when a line completes.
  logic [9:0] value_inc;
  logic [1:0] mod3_inc;
  logic [2:0] mod5_inc;
  logic [3:0] bcd_h_inc, bcd_t_inc, bcd_o_inc;
  logic       carry_o, carry_t;

  // Character at position idx of the line for the given classification/BCD value.
  function automatic logic [7:0] line_char(input logic [1:0] m3, input logic [2:0] m5,
                                           input logic [3:0] h, input logic [3:0] t,
                                           input logic [3:0] o, input logic [3:0] idx);
    logic [7:0] ch;
    logic [3:0] nd;
    logic [3:0] pos;
    logic [3:0] d;
    ch  = ChLf;
    nd  = 4'd1;
    pos = 4'd0;
    d   = 4'd0;
    if (m3 == 2'd0 && m5 == 3'd0) begin
      case (idx)
        4'd0:                            ch = 8'h46;
        4'd1:                            ch = 8'h69;
        4'd2, 4'd3, 4'd6, 4'd7:          ch = 8'h7A;
        4'd4:                            ch = 8'h42;
        4'd5:                            ch = 8'h75;
        4'd8:                            ch = ChCr;
        default:                         ch = ChLf;
      endcase
    end else if (m3 == 2'd0) begin
      case (idx)
        4'd0:       ch = 8'h46;
        4'd1:       ch = 8'h69;
        4'd2, 4'd3: ch = 8'h7A;
        4'd4:       ch = ChCr;
        default:    ch = ChLf;
      endcase
    end else if (m5 == 3'd0) begin
      case (idx)
        4'd0:       ch = 8'h42;
        4'd1:       ch = 8'h75;
        4'd2, 4'd3: ch = 8'h7A;
        4'd4:       ch = ChCr;
        default:    ch = ChLf;
      endcase
    end else begin
      // Leading-zero suppression: skip the top (3 - nd) BCD digits.
      if (h != 4'd0)      nd = 4'd3;
      else if (t != 4'd0) nd = 4'd2;
      else                nd = 4'd1;
      pos = idx + 4'd3 - nd;
      case (pos)
        4'd0:    d = h;
        4'd1:    d = t;
        default: d = o;
      endcase
      if (idx < nd)       ch = {4'h3, d};
      else if (idx == nd) ch = ChCr;
      else                ch = ChLf;
    end
    return ch;
  endfunction

  // Divider-free counter increments with decimal carry.
  always_comb begin
    value_inc = value_q + 10'd1;
    mod3_inc  = (mod3_q == 2'd2) ? 2'd0 : mod3_q + 2'd1;
    mod5_inc  = (mod5_q == 3'd4) ? 3'd0 : mod5_q + 3'd1;
    carry_o   = (bcd_o_q == 4'd9);
    carry_t   = carry_o && (bcd_t_q == 4'd9);
    bcd_o_inc = carry_o ? 4'd0 : bcd_o_q + 4'd1;
    bcd_t_inc = carry_o ? (carry_t ? 4'd0 : bcd_t_q + 4'd1) : bcd_t_q;
    bcd_h_inc = carry_t ? bcd_h_q + 4'd1 : bcd_h_q;
  end

  // Next-state and output register logic.
  always_comb begin
    logic       line_end;
    logic [7:0] first_ch;
    state_d    = state_q;
    value_d    = value_q;
    mod3_d     = mod3_q;
    mod5_d     = mod5_q;
    bcd_h_d    = bcd_h_q;
    bcd_t_d    = bcd_t_q;
    bcd_o_d    = bcd_o_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    done_d     = done_q;
    led_d      = led_q;
    line_end   = 1'b0;
    first_ch   = 8'h31;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          value_d    = 10'd1;
          mod3_d     = 2'd1;
          mod5_d     = 3'd1;
          bcd_h_d    = 4'd0;
          bcd_t_d    = 4'd0;
          bcd_o_d    = 4'd1;
          led_d      = 8'd1;
          idx_d      = 4'd0;
          state_d    = StEmit;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          tx_valid_d = 1'b1;
          tx_data_d  = 8'h31;
        end
      end
      StEmit: begin
        if (tx_valid_q && tx_ready) begin
          // LF only ever appears as the final character of a line.
          if (tx_data_q == ChLf) begin
            if (value_q == LimitVal) begin
`ifdef FIZZBUZZ_LOOP_EN
              value_d  = 10'd1;
              mod3_d   = 2'd1;
              mod5_d   = 3'd1;
              bcd_h_d  = 4'd0;
              bcd_t_d  = 4'd0;
              bcd_o_d  = 4'd1;
              led_d    = 8'd1;
              first_ch = 8'h31;
              line_end = 1'b1;
`else
              state_d    = StDone;
              busy_d     = 1'b0;
              done_d     = 1'b1;
              tx_valid_d = 1'b0;
`endif
            end else begin
              value_d  = value_inc;
              mod3_d   = mod3_inc;
              mod5_d   = mod5_inc;
              bcd_h_d  = bcd_h_inc;
              bcd_t_d  = bcd_t_inc;
              bcd_o_d  = bcd_o_inc;
              led_d    = value_inc[7:0];
              first_ch = line_char(mod3_inc, mod5_inc, bcd_h_inc, bcd_t_inc, bcd_o_inc, 4'd0);
              line_end = 1'b1;
            end
          end else begin
            idx_d     = idx_q + 4'd1;
            tx_data_d = line_char(mod3_q, mod5_q, bcd_h_q, bcd_t_q, bcd_o_q, idx_q + 4'd1);
          end
        end
      end
      StGap: begin
        if (gap_q == GapW'(1)) begin
          state_d    = StEmit;
          idx_d      = 4'd0;
          tx_valid_d = 1'b1;
          tx_data_d  = line_char(mod3_q, mod5_q, bcd_h_q, bcd_t_q, bcd_o_q, 4'd0);
        end else begin
          gap_d = gap_q - GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Start the next line either immediately or after the idle gap.
    if (line_end) begin
      idx_d = 4'd0;
      if (PAUSE_CYCLES == 0) begin
        state_d    = StEmit;
        tx_valid_d = 1'b1;
        tx_data_d  = first_ch;
      end else begin
        state_d    = StGap;
        tx_valid_d = 1'b0;
        gap_d      = GapLoad;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      value_q    <= 10'd1;
      mod3_q     <= 2'd1;
      mod5_q     <= 3'd1;
      bcd_h_q    <= 4'd0;
      bcd_t_q    <= 4'd0;
      bcd_o_q    <= 4'd1;
      idx_q      <= 4'd0;
      gap_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      led_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      value_q    <= value_d;
      mod3_q     <= mod3_d;
      mod5_q     <= mod5_d;
      bcd_h_q    <= bcd_h_d;
      bcd_t_q    <= bcd_t_d;
      bcd_o_q    <= bcd_o_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      led_q      <= led_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign led      = led_q;

endmodule

// File: tb/tb_fizzbuzz_seq.sv
// Directed bench for fizzbuzz_seq: several instances with different LIMIT/PAUSE_CYCLES,
// one selected at a time; expected bytes come from a software FizzBuzz model queue.
module tb_fizzbuzz_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       st;
  logic       rdy;
  logic [1:0] sel;

  logic       start_a [4];
  logic       ready_a [4];
  logic [7:0] data_a  [4];
  logic       valid_a [4];
  logic       busy_a  [4];
  logic       done_a  [4];
  logic [7:0] led_a   [4];

  logic [7:0] m_data, m_led;
  logic       m_valid, m_busy, m_done;

  // Route shared stimulus to the selected instance only.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      start_a[k] = (sel == 2'(k)) ? st : 1'b0;
      ready_a[k] = (sel == 2'(k)) ? rdy : 1'b0;
    end
    m_data  = data_a[sel];
    m_valid = valid_a[sel];
    m_busy  = busy_a[sel];
    m_done  = done_a[sel];
    m_led   = led_a[sel];
  end

  fizzbuzz_seq #(.LIMIT(100), .PAUSE_CYCLES(0)) u_l100 (
    .clk(clk), .rst(rst), .start(start_a[0]), .tx_data(data_a[0]), .tx_valid(valid_a[0]),
    .tx_ready(ready_a[0]), .busy(busy_a[0]), .done(done_a[0]), .led(led_a[0]));
  fizzbuzz_seq #(.LIMIT(20), .PAUSE_CYCLES(3)) u_p3 (
    .clk(clk), .rst(rst), .start(start_a[1]), .tx_data(data_a[1]), .tx_valid(valid_a[1]),
    .tx_ready(ready_a[1]), .busy(busy_a[1]), .done(done_a[1]), .led(led_a[1]));
  fizzbuzz_seq #(.LIMIT(1), .PAUSE_CYCLES(0)) u_l1 (
    .clk(clk), .rst(rst), .start(start_a[2]), .tx_data(data_a[2]), .tx_valid(valid_a[2]),
    .tx_ready(ready_a[2]), .busy(busy_a[2]), .done(done_a[2]), .led(led_a[2]));
  fizzbuzz_seq #(.LIMIT(15), .PAUSE_CYCLES(0)) u_l15 (
    .clk(clk), .rst(rst), .start(start_a[3]), .tx_data(data_a[3]), .tx_valid(valid_a[3]),
    .tx_ready(ready_a[3]), .busy(busy_a[3]), .done(done_a[3]), .led(led_a[3]));

  logic [7:0] sb_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_line(input int v);
    string s;
    if (v % 15 == 0)     s = "FizzBuzz";
    else if (v % 3 == 0) s = "Fizz";
    else if (v % 5 == 0) s = "Buzz";
    else                 s = $sformatf("%0d", v);
    for (int i = 0; i < s.len(); i++) sb_q.push_back(s[i]);
    sb_q.push_back(8'h0D);
    sb_q.push_back(8'h0A);
  endtask

  task automatic pulse_start();
    st = 1'b1;
    @(posedge clk); #1;
    st = 1'b0;
  endtask

  // Drain the scoreboard through the selected DUT; checks bytes, hold-while-stalled
  // and the number of idle cycles after each LF. Returns at the sample after the
  // final handshake.
  task automatic stream(input string tag, input int pause_exp, input bit rnd, output int lfs);
    int         cyc;
    bit         hold;
    logic [7:0] hold_d;
    bit         after_lf;
    int         gap;
    logic [7:0] exp_b;
    cyc = 0; hold = 1'b0; hold_d = 8'h00; after_lf = 1'b0; gap = 0; lfs = 0;
    while (sb_q.size() > 0 && cyc < 20000) begin
      if (hold) begin
        check({tag, "-hold-valid"}, 32'(m_valid), 32'd1);
        check({tag, "-hold-data"}, 32'(m_data), 32'(hold_d));
      end
      if (after_lf) begin
        if (m_valid) begin
          check({tag, "-gap"}, gap, pause_exp);
          after_lf = 1'b0;
        end else begin
          gap++;
        end
      end
      rdy    = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      hold   = m_valid && !rdy;
      hold_d = m_data;
      if (m_valid && rdy) begin
        exp_b = sb_q.pop_front();
        check({tag, "-byte"}, 32'(m_data), 32'(exp_b));
        if (exp_b == 8'h0A) begin
          lfs++;
          after_lf = 1'b1;
          gap = 0;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    rdy = 1'b0;
    check({tag, "-drained"}, sb_q.size(), 32'd0);
    sb_q.delete();
  endtask

  initial begin
    int lfs;
    rst = 1'b1; st = 1'b0; rdy = 1'b0; sel = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst-valid", 32'(m_valid), 32'd0);
    check("rst-data", 32'(m_data), 32'h00);
    check("rst-busy", 32'(m_busy), 32'd0);
    check("rst-done", 32'(m_done), 32'd0);
    check("rst-led", 32'(m_led), 32'h00);

`ifndef FIZZBUZZ_LOOP_EN
    // Full run, ready tied high.
    pulse_start();
    check("t1-busy", 32'(m_busy), 32'd1);
    check("t1-valid", 32'(m_valid), 32'd1);
    check("t1-first", 32'(m_data), 32'h31);
    for (int v = 1; v <= 100; v++) push_line(v);
    stream("t1", 0, 1'b0, lfs);
    check("t1-lfs", lfs, 100);
    check("t1-done", 32'(m_done), 32'd1);
    check("t1-busy-end", 32'(m_busy), 32'd0);
    check("t1-valid-end", 32'(m_valid), 32'd0);
    check("t1-led", 32'(m_led), 32'h64);

    // Restart from DONE with random backpressure.
    pulse_start();
    check("t2-done-clr", 32'(m_done), 32'd0);
    check("t2-busy", 32'(m_busy), 32'd1);
    check("t2-first", 32'(m_data), 32'h31);
    for (int v = 1; v <= 100; v++) push_line(v);
    stream("t2", 0, 1'b1, lfs);
    check("t2-lfs", lfs, 100);
    check("t2-done", 32'(m_done), 32'd1);

    // Inter-line pause of 3 cycles.
    sel = 2'd1;
    pulse_start();
    check("t3-first", 32'(m_data), 32'h31);
    for (int v = 1; v <= 20; v++) push_line(v);
    stream("t3", 3, 1'b1, lfs);
    check("t3-lfs", lfs, 20);
    check("t3-done", 32'(m_done), 32'd1);

    // Reset in the middle of "FizzBuzz" after "Fi".
    sel = 2'd0;
    pulse_start();
    for (int v = 1; v <= 14; v++) push_line(v);
    sb_q.push_back(8'h46);
    sb_q.push_back(8'h69);
    stream("t4", 0, 1'b1, lfs);
    check("t4-mid", 32'(m_data), 32'h7A);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t4-rst-valid", 32'(m_valid), 32'd0);
    check("t4-rst-data", 32'(m_data), 32'h00);
    check("t4-rst-busy", 32'(m_busy), 32'd0);
    check("t4-rst-led", 32'(m_led), 32'h00);
    pulse_start();
    check("t4-restart", 32'(m_data), 32'h31);
    check("t4-done", 32'(m_done), 32'd0);

    // LIMIT=1: start ignored mid-run, then rerun from DONE.
    sel = 2'd2;
    pulse_start();
    check("t5-busy", 32'(m_busy), 32'd1);
    check("t5-first", 32'(m_data), 32'h31);
    st = 1'b1; rdy = 1'b1;
    @(posedge clk); #1;
    st = 1'b0; rdy = 1'b0;
    check("t5-ign-start", 32'(m_data), 32'h0D);
    check("t5-ign-busy", 32'(m_busy), 32'd1);
    sb_q.push_back(8'h0D);
    sb_q.push_back(8'h0A);
    stream("t5a", 0, 1'b0, lfs);
    check("t5-done", 32'(m_done), 32'd1);
    check("t5-busy-end", 32'(m_busy), 32'd0);
    check("t5-led", 32'(m_led), 32'h01);
    pulse_start();
    check("t5-redone", 32'(m_done), 32'd0);
    check("t5-rebusy", 32'(m_busy), 32'd1);
    push_line(1);
    stream("t5b", 0, 1'b1, lfs);
    check("t5b-lfs", lfs, 1);
    check("t5b-done", 32'(m_done), 32'd1);
    check("t5b-busy", 32'(m_busy), 32'd0);
`else
    // Looping build: line after "FizzBuzz" wraps back to "1".
    sel = 2'd3;
    pulse_start();
    check("loop-first", 32'(m_data), 32'h31);
    for (int v = 1; v <= 15; v++) push_line(v);
    push_line(1);
    stream("loop", 0, 1'b1, lfs);
    check("loop-lfs", lfs, 16);
    for (int i = 0; i < 3; i++) begin
      check("loop-done", 32'(m_done), 32'd0);
      check("loop-busy", 32'(m_busy), 32'd1);
      @(posedge clk); #1;
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
